// File: rtl/keypad_pkg.sv
// keypad_pkg: key layout lookup, FSM states and bounce LFSR taps for the keypad emulator.
package keypad_pkg;
  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HELD, BOUNCE_OUT, GAP} state_t;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  function automatic logic [3:0] key_pos(input logic [3:0] code);
    key_pos = 4'h0;
    case (code)
      4'h1: key_pos = 4'h0;
      4'h2: key_pos = 4'h1;
      4'h3: key_pos = 4'h2;
      4'hA: key_pos = 4'h3;
      4'h4: key_pos = 4'h4;
      4'h5: key_pos = 4'h5;
      4'h6: key_pos = 4'h6;
      4'hB: key_pos = 4'h7;
      4'h7: key_pos = 4'h8;
      4'h8: key_pos = 4'h9;
      4'h9: key_pos = 4'hA;
      4'hC: key_pos = 4'hB;
      4'hE: key_pos = 4'hC;
      4'h0: key_pos = 4'hD;
      4'hF: key_pos = 4'hE;
      4'hD: key_pos = 4'hF;
    endcase
  endfunction
endpackage

// File: rtl/bounce_lfsr.sv
// bounce_lfsr: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advancing only while enabled.
module bounce_lfsr import keypad_pkg::*; #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic ph1,
  input  logic reset,
  input  logic en,
  output logic bounce
);
  logic [7:0] q;
  always_ff @(posedge ph1 or posedge reset)
    if (reset) q <= SEED;
    else if (en) q <= {q[6:0], ^(q & LFSR_TAPS)};
  assign bounce = q[0];
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: answers a 4x4 keypad column scan on rows, pressing one requested key
// at a time with contact bounce, programmable hold and an inter-key gap.
module keypad_emulator import keypad_pkg::*; #(
  parameter int BOUNCE_CYCLES = 8,
  parameter int GAP_CYCLES = 4,
  parameter int HOLD_W = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic ph1,
  input  logic reset,
  input  logic [3:0] columns,
  output logic [3:0] rows,
  input  logic key_valid,
  input  logic [3:0] key_code,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic key_ready,
  output logic pressed,
  output logic done
);
  localparam int MX = BOUNCE_CYCLES > GAP_CYCLES ? BOUNCE_CYCLES : GAP_CYCLES;
  localparam int CW = HOLD_W > $clog2(MX + 1) ? HOLD_W : $clog2(MX + 1);
  localparam logic [CW-1:0] B_LD = CW'(BOUNCE_CYCLES);
  localparam logic [CW-1:0] G_LD = CW'(GAP_CYCLES);
  localparam bit NB = BOUNCE_CYCLES == 0;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] row_r, col_r;
  logic [HOLD_W-1:0] hold_r;
  logic last, bounce;
  function automatic logic [CW-1:0] hold_ld(input logic [HOLD_W-1:0] h);
    return h == '0 ? CW'(1) : CW'(h);
  endfunction
  bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .ph1(ph1),
    .reset(reset),
    .en(state == BOUNCE_IN || state == BOUNCE_OUT),
    .bounce(bounce)
  );
  assign last = cnt == CW'(1);
  assign key_ready = state == IDLE;
  assign done = state == GAP && last;
  assign pressed = state == HELD || ((state == BOUNCE_IN || state == BOUNCE_OUT) && bounce);
  // Purely combinational like a real contact: no register between columns and rows.
  assign rows = (pressed && columns[col_r]) ? 4'b0001 << row_r : 4'b0000;
  always_comb begin
    state_n = state;
    cnt_n = state == IDLE ? cnt : cnt - CW'(1);
    case (state)
      IDLE:
        if (key_valid) begin
          state_n = NB ? HELD : BOUNCE_IN;
          cnt_n = NB ? hold_ld(hold_cycles) : B_LD;
        end
      BOUNCE_IN:
        if (last) begin
          state_n = HELD;
          cnt_n = hold_ld(hold_r);
        end
      HELD:
        if (last) begin
          state_n = NB ? GAP : BOUNCE_OUT;
          cnt_n = NB ? G_LD : B_LD;
        end
      BOUNCE_OUT:
        if (last) begin
          state_n = GAP;
          cnt_n = G_LD;
        end
      GAP:
        if (last) begin
          state_n = IDLE;
          cnt_n = '0;
        end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge ph1 or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      row_r <= '0;
      col_r <= '0;
      hold_r <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (key_valid && key_ready) begin
        {row_r, col_r} <= key_pos(key_code);
        hold_r <= hold_cycles;
      end
    end
endmodule
